// File: rtl/audio_pkg.sv
// Shared widths and the mixer-to-I2S sample conversion used by the I2S transmitter.
package audio_pkg;

  localparam int SAMPLE_W   = 11;
  localparam int I2S_W      = 16;
  localparam int FRAME_BITS = 32;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Flipping the MSB turns the unsigned mixer sum into two's complement around mid-scale.
  function automatic logic [I2S_W-1:0] to_i2s(input logic [SAMPLE_W-1:0] a);
    return {~a[SAMPLE_W-1], a[SAMPLE_W-2:0], {(I2S_W-SAMPLE_W){1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider: toggles bclk every DIV system clocks and flags the clock in
// which bclk is about to fall so the serial side can update alongside it.
module i2s_clkgen #(
  parameter int DIV = 14
) (
  input  logic clock_i,
  input  logic reset_ni,
  output logic bclk_o,
  output logic fall_evt_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == LAST);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    bclk_d = wrap ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign fall_evt_o = wrap & bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter for the left/right mixer sums: 32 bclk per frame,
// lrck leads each channel MSB by one bclk, and the L/R pair is latched once per frame.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DIV = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] laudio,
  input  logic [SAMPLE_W-1:0] raudio,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_data,
  output logic                sample
);

  localparam logic [BIT_CNT_W-1:0] N_LAST    = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] N_R_FIRST = BIT_CNT_W'(FRAME_BITS / 2 - 1);

  logic                 fallEvt;
  logic [BIT_CNT_W-1:0] n_q, n_d;
  chan_e                lrck_q, lrck_d;
  logic                 data_q, data_d;
  logic                 sample_q, sample_d;
  logic [I2S_W-1:0]     l16_q, l16_d, r16_q, r16_d;
  logic [3:0]           bitIdx;

  i2s_clkgen #(.DIV(DIV)) u_clkgen (
    .clock_i    (clock),
    .reset_ni   (reset),
    .bclk_o     (i2s_bclk),
    .fall_evt_o (fallEvt)
  );

  // Within each 16-bit half-frame the word bit is 15 minus the low four counter bits.
  always_comb begin
    n_d      = n_q;
    lrck_d   = lrck_q;
    data_d   = data_q;
    sample_d = 1'b0;
    l16_d    = l16_q;
    r16_d    = r16_q;
    bitIdx   = 4'd0;
    if (fallEvt) begin
      n_d    = n_q + 1'b1;
      bitIdx = ~n_d[3:0];
      lrck_d = (n_d >= N_R_FIRST && n_d != N_LAST) ? CH_RIGHT : CH_LEFT;
      data_d = n_d[4] ? r16_q[bitIdx] : l16_q[bitIdx];
      if (n_d == N_LAST) begin
        l16_d    = to_i2s(laudio);
        r16_d    = to_i2s(raudio);
        sample_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      n_q      <= N_LAST;
      lrck_q   <= CH_LEFT;
      data_q   <= 1'b0;
      sample_q <= 1'b0;
      l16_q    <= '0;
      r16_q    <= '0;
    end else begin
      n_q      <= n_d;
      lrck_q   <= lrck_d;
      data_q   <= data_d;
      sample_q <= sample_d;
      l16_q    <= l16_d;
      r16_q    <= r16_d;
    end
  end

  assign i2s_lrck = lrck_q;
  assign i2s_data = data_q;
  assign sample   = sample_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a cycle-count reference model predicts every output, and an
// I2S receiver rebuilds the transmitted words from the bclk/lrck/data pins.
module tb_i2s_tx;

  localparam int DIV       = 2;
  localparam int FRAME_CLK = 64 * DIV;

  logic        clock  = 1'b0;
  logic        reset  = 1'b0;
  logic [10:0] laudio = '0;
  logic [10:0] raudio = '0;
  logic        i2sBclk, i2sLrck, i2sData, sample;

  int checks = 0;
  int passes = 0;

  int          cyc = 0;
  logic [15:0] txL = '0, txR = '0;
  logic [3:0]  expVec = '0;
  logic [15:0] expL[$], expR[$], rxL[$], rxR[$];

  logic        prevB = 1'b0, lastLr = 1'b0, curCh = 1'b0;
  int          bits = 0;
  logic [15:0] sh = '0;

  i2s_tx #(.DIV(DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .laudio   (laudio),
    .raudio   (raudio),
    .i2s_bclk (i2sBclk),
    .i2s_lrck (i2sLrck),
    .i2s_data (i2sData),
    .sample   (sample)
  );

  always #5 clock = ~clock;

  // Offset-binary value (a - 1024) * 32, wrapped into 16 bits.
  function automatic logic [15:0] refWord(input logic [10:0] a);
    int v;
    v = (int'(a) * 32 + 32768) % 65536;
    return v[15:0];
  endfunction

  // Advance one clock: predict outputs from the clock count, then decode pins like a DAC would.
  task automatic step();
    int k, n;
    logic eb, el, ed, es;
    @(posedge clock);
    if (!reset) begin
      cyc = 0; txL = '0; txR = '0; expVec = '0;
      expL.delete(); expR.delete();
      expL.push_back(16'h0000); expR.push_back(16'h0000);
      rxL.delete(); rxR.delete();
      lastLr = 1'b0; curCh = 1'b0; bits = 0; sh = '0;
    end else begin
      cyc++;
      k  = cyc / (2 * DIV);
      eb = ((cyc / DIV) % 2) == 1;
      el = 1'b0;
      ed = 1'b0;
      if (k > 0) begin
        n  = (k - 1) % 32;
        el = (n >= 15 && n <= 30);
        ed = (n < 16) ? txL[15 - n] : txR[31 - n];
      end
      es = (cyc % FRAME_CLK) == 0;
      expVec = {eb, el, ed, es};
      if (es) begin
        txL = refWord(laudio);
        txR = refWord(raudio);
        expL.push_back(txL);
        expR.push_back(txR);
      end
    end
    @(negedge clock);
    if (i2sBclk && !prevB) begin
      if (lastLr != curCh) begin
        if (bits >= 16) begin
          if (curCh) rxR.push_back(sh);
          else       rxL.push_back(sh);
        end
        bits  = 0;
        curCh = lastLr;
      end
      sh     = {sh[14:0], i2sData};
      bits++;
      lastLr = i2sLrck;
    end
    prevB = i2sBclk;
  endtask

  task automatic test_reset();
    int firstRise = -1, firstFall = -1;
    logic pb = 1'b0;
    laudio = 11'($urandom); raudio = 11'($urandom);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({i2sBclk, i2sLrck, i2sData, sample} !== 4'b0000)
        $display("[TB] FAIL reset_hold clk=%0d got=%b exp=0000", i, {i2sBclk, i2sLrck, i2sData, sample});
      else passes++;
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({i2sBclk, i2sLrck, i2sData, sample} !== expVec)
        $display("[TB] FAIL reset_release cyc=%0d got=%b exp=%b", cyc, {i2sBclk, i2sLrck, i2sData, sample}, expVec);
      else passes++;
      if (i2sBclk && !pb && firstRise < 0) firstRise = cyc;
      if (!i2sBclk && pb && firstFall < 0) firstFall = cyc;
      pb = i2sBclk;
    end
    checks++;
    if (firstRise !== 2) $display("[TB] FAIL first_rise got=%0d exp=2", firstRise);
    else passes++;
    checks++;
    if (firstFall !== 4) $display("[TB] FAIL first_fall got=%0d exp=4", firstFall);
    else passes++;
  endtask

  task automatic test_free_run();
    int lastRise = -1, lastSample = -1, lowCnt = 0, highCnt = 0, pulses = 0, startCyc;
    logic pb, pl, ps;
    pb = i2sBclk; pl = i2sLrck; ps = sample; startCyc = cyc;
    for (int i = 0; i < 400; i++) begin
      laudio = 11'($urandom); raudio = 11'($urandom);
      step();
      checks++;
      if ({i2sBclk, i2sLrck, i2sData, sample} !== expVec)
        $display("[TB] FAIL free_vec cyc=%0d got=%b exp=%b", cyc, {i2sBclk, i2sLrck, i2sData, sample}, expVec);
      else passes++;
      if (i2sBclk && !pb) begin
        if (lastRise >= 0) begin
          checks++;
          if (cyc - lastRise !== 2 * DIV)
            $display("[TB] FAIL bclk_period got=%0d exp=%0d", cyc - lastRise, 2 * DIV);
          else passes++;
        end
        lastRise = cyc;
      end
      if (sample) begin
        pulses++;
        checks++;
        if (ps || !pl || i2sLrck)
          $display("[TB] FAIL sample_align prevSample=%b prevLrck=%b lrck=%b exp=0/1/0", ps, pl, i2sLrck);
        else passes++;
        if (lastSample >= 0) begin
          checks++;
          if (cyc - lastSample !== FRAME_CLK || lowCnt !== FRAME_CLK / 2 || highCnt !== FRAME_CLK / 2)
            $display("[TB] FAIL frame_len got=%0d low=%0d high=%0d exp=%0d/%0d/%0d",
                     cyc - lastSample, lowCnt, highCnt, FRAME_CLK, FRAME_CLK / 2, FRAME_CLK / 2);
          else passes++;
        end
        lastSample = cyc; lowCnt = 0; highCnt = 0;
      end
      if (i2sLrck) highCnt++; else lowCnt++;
      pb = i2sBclk; pl = i2sLrck; ps = sample;
    end
    checks++;
    if (pulses !== cyc / FRAME_CLK - startCyc / FRAME_CLK)
      $display("[TB] FAIL pulse_count got=%0d exp=%0d", pulses, cyc / FRAME_CLK - startCyc / FRAME_CLK);
    else passes++;
  endtask

  task automatic test_full_scale();
    laudio = 11'h7FF; raudio = 11'h000;
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 3 * FRAME_CLK + 20; i++) begin
      step();
      checks++;
      if ({i2sBclk, i2sLrck, i2sData, sample} !== expVec)
        $display("[TB] FAIL fs_vec cyc=%0d got=%b exp=%b", cyc, {i2sBclk, i2sLrck, i2sData, sample}, expVec);
      else passes++;
    end
    checks++;
    if (rxL.size() < 3 || rxR.size() < 3) begin
      $display("[TB] FAIL fs_words got=%0d/%0d exp>=3", rxL.size(), rxR.size());
    end else begin
      passes++;
      checks++;
      if (rxL[0] !== 16'h0000 || rxR[0] !== 16'h0000)
        $display("[TB] FAIL fs_first got=%h/%h exp=0000/0000", rxL[0], rxR[0]);
      else passes++;
      checks++;
      if (rxL[1] !== 16'h7FE0 || rxR[1] !== 16'h8000)
        $display("[TB] FAIL fs_second got=%h/%h exp=7fe0/8000", rxL[1], rxR[1]);
      else passes++;
      checks++;
      if (rxL[2] !== 16'h7FE0 || rxR[2] !== 16'h8000)
        $display("[TB] FAIL fs_third got=%h/%h exp=7fe0/8000", rxL[2], rxR[2]);
      else passes++;
    end
  endtask

  task automatic test_mid_scale();
    logic pb = 1'b0, pl = 1'b0, armed = 1'b0, done = 1'b0;
    logic bit5 = 1'bx, bit6 = 1'bx;
    int rc = 0;
    laudio = 11'h400; raudio = 11'h401;
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 2 * FRAME_CLK + 20; i++) begin
      step();
      checks++;
      if ({i2sBclk, i2sLrck, i2sData, sample} !== expVec)
        $display("[TB] FAIL ms_vec cyc=%0d got=%b exp=%b", cyc, {i2sBclk, i2sLrck, i2sData, sample}, expVec);
      else passes++;
      if (cyc > FRAME_CLK && !armed && !done && i2sLrck && !pl) begin
        armed = 1'b1; rc = 0;
      end else if (armed && i2sBclk && !pb) begin
        // The first rise after lrck goes high still carries the left LSB.
        rc++;
        if (rc == 11) bit6 = i2sData;
        if (rc == 12) begin bit5 = i2sData; armed = 1'b0; done = 1'b1; end
      end
      pb = i2sBclk; pl = i2sLrck;
    end
    checks++;
    if (bit5 !== 1'b1 || bit6 !== 1'b0)
      $display("[TB] FAIL ms_r_bit5 got=%b%b exp=01 (bit6,bit5)", bit6, bit5);
    else passes++;
    checks++;
    if (rxL.size() < 2 || rxR.size() < 2) begin
      $display("[TB] FAIL ms_words got=%0d/%0d exp>=2", rxL.size(), rxR.size());
    end else begin
      passes++;
      checks++;
      if (rxL[1] !== 16'h0000 || rxR[1] !== 16'h0020)
        $display("[TB] FAIL ms_second got=%h/%h exp=0000/0020", rxL[1], rxR[1]);
      else passes++;
    end
  endtask

  task automatic test_coherent();
    int cnt;
    laudio = 11'($urandom); raudio = 11'($urandom);
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 4 * FRAME_CLK + 20; i++) begin
      laudio = laudio + 11'd1;
      raudio = 11'($urandom);
      step();
      checks++;
      if ({i2sBclk, i2sLrck, i2sData, sample} !== expVec)
        $display("[TB] FAIL coh_vec cyc=%0d got=%b exp=%b", cyc, {i2sBclk, i2sLrck, i2sData, sample}, expVec);
      else passes++;
    end
    cnt = (rxR.size() < expR.size()) ? rxR.size() : expR.size();
    checks++;
    if (cnt < 4) $display("[TB] FAIL coh_count got=%0d exp>=4", cnt);
    else passes++;
    for (int i = 0; i < cnt; i++) begin
      checks++;
      if (rxL[i] !== expL[i] || rxR[i] !== expR[i])
        $display("[TB] FAIL coh_pair idx=%0d got=%h/%h exp=%h/%h", i, rxL[i], rxR[i], expL[i], expR[i]);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0; step(); reset = 1'b1;
    while (cyc < 85) begin
      laudio = 11'($urandom); raudio = 11'($urandom);
      step();
    end
    reset = 1'b0;
    step();
    checks++;
    if ({i2sBclk, i2sLrck, i2sData, sample} !== 4'b0000)
      $display("[TB] FAIL mid_reset got=%b exp=0000", {i2sBclk, i2sLrck, i2sData, sample});
    else passes++;
    reset = 1'b1;
    laudio = 11'($urandom) | 11'h001; raudio = 11'($urandom) | 11'h001;
    for (int i = 0; i < 2 * FRAME_CLK + 20; i++) begin
      step();
      checks++;
      if ({i2sBclk, i2sLrck, i2sData, sample} !== expVec)
        $display("[TB] FAIL mr_vec cyc=%0d got=%b exp=%b", cyc, {i2sBclk, i2sLrck, i2sData, sample}, expVec);
      else passes++;
    end
    checks++;
    if (rxL.size() < 2 || rxR.size() < 2 || expL.size() < 2) begin
      $display("[TB] FAIL mr_words got=%0d/%0d exp>=2", rxL.size(), rxR.size());
    end else begin
      passes++;
      checks++;
      if (rxL[0] !== 16'h0000 || rxR[0] !== 16'h0000)
        $display("[TB] FAIL mr_first got=%h/%h exp=0000/0000", rxL[0], rxR[0]);
      else passes++;
      checks++;
      if (rxL[1] !== expL[1] || rxR[1] !== expR[1])
        $display("[TB] FAIL mr_second got=%h/%h exp=%h/%h", rxL[1], rxR[1], expL[1], expR[1]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_full_scale();
    test_mid_scale();
    test_coherent();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
